// File: rtl/pe_loader_if.sv
// Bundles the launch controls, source-memory read port and PE write ports of pe_loader.
// The loader itself takes the slave modport.
interface pe_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  fil_len;
    logic [LEN_WIDTH-1:0]  ifm_len;
    logic                  mem_ren;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] data_in_fil;
    logic                  w_en_fil;
    logic                  ready_fil;
    logic [DATA_WIDTH+1:0] data_in_ifm;
    logic                  w_en_ifm;
    logic                  ready_ifm;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, base_addr, fil_len, ifm_len, mem_rdata, ready_fil, ready_ifm,
        output mem_ren, mem_addr, data_in_fil, w_en_fil, data_in_ifm, w_en_ifm, busy, done
    );

    modport master (
        output start, base_addr, fil_len, ifm_len, mem_rdata, ready_fil, ready_ifm,
        input  mem_ren, mem_addr, data_in_fil, w_en_fil, data_in_ifm, w_en_ifm, busy, done
    );
endinterface

// File: rtl/pe_loader.sv
// Streams a filter block, then an IFM block, from contiguous source memory into a PE,
// one word per RD/CAP/WR pass; IFM words carry first/last row tags.
module pe_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    pe_loader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;

    localparam logic PH_FIL = 1'b0;
    localparam logic PH_IFM = 1'b1;

    state_t                r_state;
    logic                  r_phase;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_ren;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [LEN_WIDTH-1:0]  r_ifm_len;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [1:0]            r_tag;
    logic                  r_done;

    logic w_wr_fil;
    logic w_wr_ifm;
    logic w_wr;
    logic w_last;

    // A write commits in the WR cycle where the active phase's ready is high.
    assign w_wr_fil = (r_state == WR) && (r_phase == PH_FIL) && bus.ready_fil;
    assign w_wr_ifm = (r_state == WR) && (r_phase == PH_IFM) && bus.ready_ifm;
    assign w_wr     = w_wr_fil || w_wr_ifm;
    assign w_last   = (r_rem == LEN_WIDTH'(1));

    assign bus.mem_ren     = r_mem_ren;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.data_in_fil = r_hold;
    assign bus.data_in_ifm = {r_tag, r_hold};
    assign bus.w_en_fil    = w_wr_fil;
    assign bus.w_en_ifm    = w_wr_ifm;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_phase    <= PH_FIL;
            r_addr     <= '0;
            r_mem_addr <= '0;
            r_mem_ren  <= 1'b0;
            r_rem      <= '0;
            r_ifm_len  <= '0;
            r_hold     <= '0;
            r_tag      <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_mem_ren  <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_addr    <= bus.base_addr;
                        r_ifm_len <= bus.ifm_len;
                        if (bus.fil_len != '0) begin
                            r_phase    <= PH_FIL;
                            r_rem      <= bus.fil_len;
                            r_mem_ren  <= 1'b1;
                            r_mem_addr <= bus.base_addr;
                            r_state    <= RD;
                        end else if (bus.ifm_len != '0) begin
                            r_phase    <= PH_IFM;
                            r_rem      <= bus.ifm_len;
                            r_mem_ren  <= 1'b1;
                            r_mem_addr <= bus.base_addr;
                            r_state    <= RD;
                        end else begin
                            r_rem   <= '0;
                            r_state <= FIN;
                        end
                    end
                end
                RD: begin
                    r_state <= CAP;
                end
                CAP: begin
                    // Read data is valid here; first word is when nothing has been consumed yet.
                    r_hold  <= bus.mem_rdata;
                    r_tag   <= (r_phase == PH_IFM) ? {(r_rem == r_ifm_len), w_last} : 2'b00;
                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                    r_state <= WR;
                end
                WR: begin
                    if (w_wr) begin
                        if (!w_last) begin
                            r_rem      <= r_rem - LEN_WIDTH'(1);
                            r_mem_ren  <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_state    <= RD;
                        end else if ((r_phase == PH_FIL) && (r_ifm_len != '0)) begin
                            r_phase    <= PH_IFM;
                            r_rem      <= r_ifm_len;
                            r_mem_ren  <= 1'b1;
                            r_mem_addr <= r_addr;
                            r_state    <= RD;
                        end else begin
                            r_rem   <= '0;
                            r_state <= FIN;
                        end
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_loader.sv
// Directed bench for pe_loader: a registered memory model feeds reads, a negedge
// monitor logs strobes, reads and done, and each scenario is compared to hand-computed values.
module tb_pe_loader;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int LW   = 6;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pe_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    pe_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] mem [256];
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    logic [DW-1:0]   fil_q[$];
    logic [DW+1:0]   ifm_q[$];
    logic [AW-1:0]   rd_q[$];
    int              n_done;
    int              done_cyc;
    int              first_fil_cyc;
    int              n_both;
    logic [DW-1:0]   log_fd  [LOGN];
    logic            log_ren [LOGN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

    always @(negedge clk) begin
        if (bus.w_en_fil === 1'b1) begin
            fil_q.push_back(bus.data_in_fil);
            if (first_fil_cyc < 0) first_fil_cyc = cyc;
        end
        if (bus.w_en_ifm === 1'b1) ifm_q.push_back(bus.data_in_ifm);
        if (bus.mem_ren === 1'b1) rd_q.push_back(bus.mem_addr);
        if (bus.w_en_fil === 1'b1 && bus.w_en_ifm === 1'b1) n_both++;
        if (bus.done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (cyc < LOGN) begin
            log_fd[cyc]  = bus.data_in_fil;
            log_ren[cyc] = bus.mem_ren;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        fil_q.delete();
        ifm_q.delete();
        rd_q.delete();
        n_done = 0;
        done_cyc = -1;
        first_fil_cyc = -1;
        n_both = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] f,
                            input logic [LW-1:0] i, output int s);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.base_addr = b;
        bus.fil_len = f;
        bus.ifm_len = i;
        s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (n_done != 0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {bus.mem_ren, bus.w_en_fil, bus.w_en_ifm, bus.busy, bus.done,
                    bus.mem_addr, bus.data_in_fil, bus.data_in_ifm}, 64'd0);
    endtask

    initial begin
        int s;
        logic [DW-1:0] exp_fil[$];
        logic [DW+1:0] exp_ifm[$];
        logic [AW-1:0] exp_rd[$];

        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.fil_len = '0;
        bus.ifm_len = '0;
        bus.ready_fil = 1'b1;
        bus.ready_ifm = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i + 1);
        clear_logs();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Filter 6 words then IFM 5 words from address 0
        clear_logs();
        do_start(8'h00, 6'd6, 6'd5, s);
        @(negedge clk);
        check("t1_busy", 64'(bus.busy), 64'd1);
        wait_done("t1", 200);
        exp_fil = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        exp_ifm = '{18'h20007, 18'h00008, 18'h00009, 18'h0000A, 18'h1000B};
        check("t1_fil_count", 64'(fil_q.size()), 64'd6);
        for (int i = 0; i < exp_fil.size(); i++)
            check($sformatf("t1_fil%0d", i), 64'(i < fil_q.size() ? fil_q[i] : 'x), 64'(exp_fil[i]));
        check("t1_ifm_count", 64'(ifm_q.size()), 64'd5);
        for (int i = 0; i < exp_ifm.size(); i++)
            check($sformatf("t1_ifm%0d", i), 64'(i < ifm_q.size() ? ifm_q[i] : 'x), 64'(exp_ifm[i]));
        check("t1_done_latency", 64'(done_cyc - s), 64'd35);
        check("t1_done_once", 64'(n_done), 64'd1);
        check("t1_no_overlap", 64'(n_both), 64'd0);
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Single-word IFM row, no filter
        mem[4] = 16'h00AA;
        clear_logs();
        do_start(8'h04, 6'd0, 6'd1, s);
        wait_done("t2", 50);
        check("t2_fil_count", 64'(fil_q.size()), 64'd0);
        check("t2_ifm_count", 64'(ifm_q.size()), 64'd1);
        check("t2_ifm0", 64'(ifm_q.size() > 0 ? ifm_q[0] : 'x), 64'h300AA);
        check("t2_read_addr", 64'(rd_q.size() > 0 ? rd_q[0] : 'x), 64'h04);
        check("t2_done_latency", 64'(done_cyc - s), 64'd5);

        // Empty job
        clear_logs();
        do_start(8'h10, 6'd0, 6'd0, s);
        wait_done("t3", 20);
        check("t3_reads", 64'(rd_q.size()), 64'd0);
        check("t3_writes", 64'(fil_q.size() + ifm_q.size()), 64'd0);
        check("t3_done_latency", 64'(done_cyc - s), 64'd2);

        // Filter ready held low for the first 4 WR cycles
        mem[8'h10] = 16'h1234;
        mem[8'h11] = 16'h5678;
        clear_logs();
        bus.ready_fil = 1'b0;
        do_start(8'h10, 6'd2, 6'd0, s);
        repeat (6) @(posedge clk);
        #1;
        bus.ready_fil = 1'b1;
        wait_done("t4", 50);
        check("t4_first_write_cyc", 64'(first_fil_cyc - s), 64'd7);
        for (int c = 3; c <= 7; c++)
            check($sformatf("t4_data_stable_c%0d", c), 64'(log_fd[s + c]), 64'h1234);
        for (int c = 3; c <= 7; c++)
            check($sformatf("t4_no_read_c%0d", c), 64'(log_ren[s + c]), 64'd0);
        exp_fil = '{16'h1234, 16'h5678};
        check("t4_fil_count", 64'(fil_q.size()), 64'd2);
        for (int i = 0; i < exp_fil.size(); i++)
            check($sformatf("t4_fil%0d", i), 64'(i < fil_q.size() ? fil_q[i] : 'x), 64'(exp_fil[i]));
        check("t4_reads", 64'(rd_q.size()), 64'd2);
        check("t4_done_latency", 64'(done_cyc - s), 64'd12);

        // Address wrap at the top of memory
        mem[8'hFE] = 16'hBEEF;
        mem[8'hFF] = 16'hCAFE;
        mem[8'h00] = 16'hF00D;
        clear_logs();
        do_start(8'hFE, 6'd3, 6'd0, s);
        wait_done("t5", 50);
        exp_rd = '{8'hFE, 8'hFF, 8'h00};
        exp_fil = '{16'hBEEF, 16'hCAFE, 16'hF00D};
        check("t5_read_count", 64'(rd_q.size()), 64'd3);
        for (int i = 0; i < exp_rd.size(); i++)
            check($sformatf("t5_rd%0d", i), 64'(i < rd_q.size() ? rd_q[i] : 'x), 64'(exp_rd[i]));
        for (int i = 0; i < exp_fil.size(); i++)
            check($sformatf("t5_fil%0d", i), 64'(i < fil_q.size() ? fil_q[i] : 'x), 64'(exp_fil[i]));
        check("t5_done_latency", 64'(done_cyc - s), 64'd11);

        // Ignored start while busy, then reset during the third IFM word
        for (int i = 0; i < 5; i++) mem[8'h20 + i] = 16'h0100 + 16'(i);
        clear_logs();
        do_start(8'h20, 6'd0, 6'd5, s);
        bus.start = 1'b1;
        bus.base_addr = 8'h80;
        bus.fil_len = 6'd1;
        bus.ifm_len = 6'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs_zero("t6_reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_done", 64'(n_done), 64'd0);
        check("t6_fil_count", 64'(fil_q.size()), 64'd0);
        check("t6_ifm_count", 64'(ifm_q.size()), 64'd2);
        check("t6_ifm0", 64'(ifm_q.size() > 0 ? ifm_q[0] : 'x), 64'h20100);
        check("t6_ifm1", 64'(ifm_q.size() > 1 ? ifm_q[1] : 'x), 64'h00101);
        exp_rd = '{8'h20, 8'h21, 8'h22};
        check("t6_read_count", 64'(rd_q.size()), 64'd3);
        for (int i = 0; i < exp_rd.size(); i++)
            check($sformatf("t6_rd%0d", i), 64'(i < rd_q.size() ? rd_q[i] : 'x), 64'(exp_rd[i]));
        check("t6_idle_busy", 64'(bus.busy), 64'd0);

        clear_logs();
        do_start(8'h20, 6'd0, 6'd5, s);
        wait_done("t7", 100);
        exp_ifm = '{18'h20100, 18'h00101, 18'h00102, 18'h00103, 18'h10104};
        check("t7_ifm_count", 64'(ifm_q.size()), 64'd5);
        for (int i = 0; i < exp_ifm.size(); i++)
            check($sformatf("t7_ifm%0d", i), 64'(i < ifm_q.size() ? ifm_q[i] : 'x), 64'(exp_ifm[i]));
        check("t7_done_latency", 64'(done_cyc - s), 64'd17);
        check("t7_done_once", 64'(n_done), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_loader.md
PE_LOADER -- requirements
Module: pe_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one data word.
REQ-002 Parameter ADDR_WIDTH, default 8, source-memory address width.
REQ-003 Parameter LEN_WIDTH, default 6, width of the word-count inputs.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle launch pulse; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first source address; sampled with start.
REQ-008 fil_len  input  LEN_WIDTH  filter word count; sampled with start.
REQ-009 ifm_len  input  LEN_WIDTH  IFM word count; sampled with start.
REQ-010 mem_ren  output  1  source-memory read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  source-memory read address.
REQ-012 mem_rdata  input  DATA_WIDTH  read data, valid exactly one cycle after mem_ren.
REQ-013 data_in_fil  output  DATA_WIDTH  filter word to PE.
REQ-014 w_en_fil  output  1  filter write strobe to PE.
REQ-015 ready_fil  input  1  PE filter buffer can accept a word.
REQ-016 data_in_ifm  output  DATA_WIDTH+2  {tag[1:0], word} to PE; tag 10 first, 00 middle, 01 last, 11 single-word row.
REQ-017 w_en_ifm  output  1  IFM write strobe to PE.
REQ-018 ready_ifm  input  1  PE IFM buffer can accept a word.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse after the last write.

Function
REQ-021 FSM states: IDLE, RD, CAP, WR, FIN; phase flag selects FIL (first) or IFM.
REQ-022 IDLE + start: latch inputs; addr<=base_addr; phase<=FIL if fil_len!=0, else IFM if ifm_len!=0, else go directly to FIN.
REQ-023 RD: mem_ren=1, mem_addr=addr for exactly one cycle; next state CAP.
REQ-024 CAP: hold register<=mem_rdata; addr<=addr+1 (mod 2^ADDR_WIDTH); next state WR.
REQ-025 WR: strobe of current phase asserted for exactly one cycle, in the cycle ready of that phase is high; otherwise wait in WR, strobe low.
REQ-026 Data output holds the captured word from CAP exit until the next CAP; strobes never high together.
REQ-027 After a write, remaining count of phase decrements; nonzero -> RD; zero in FIL -> IFM phase (RD) if ifm_len!=0 else FIN; zero in IFM -> FIN.
REQ-028 IFM addresses continue from base_addr+fil_len without gap.
REQ-029 IFM tag from word index i of N: i=0,N=1 -> 11; i=0 -> 10; i=N-1 -> 01; else 00.
REQ-030 FIN: done=1 for one cycle; next state IDLE.
REQ-031 Minimum per-word cost 3 cycles (RD, CAP, WR with ready high); start to done = 3*(fil_len+ifm_len)+2 cycles with ready held high.
REQ-032 start while busy ignored; latched lengths/address unaffected.
REQ-033 ready deassertion mid-transfer stalls only in WR; no read issued while stalled.

Reset
REQ-034 rst_n low at any clock edge, including mid-transfer: state<=IDLE, counts and addr<=0, hold register<=0.
REQ-035 During and after reset: mem_ren, w_en_fil, w_en_ifm, busy, done = 0; mem_addr, data_in_fil, data_in_ifm = 0.
REQ-036 An interrupted transfer is abandoned; no done pulse is issued for it.

Verification
REQ-037 base_addr=0, fil_len=6, ifm_len=5, ready held high, mem[i]=i+1 -> fil writes 1..6, ifm writes {10,7},{00,8},{00,9},{00,10},{01,11}; done 35 cycles after start.
REQ-038 fil_len=0, ifm_len=1, base_addr=4, mem[4]=0x00AA -> no fil write; one ifm write {11,0x00AA}; then done.
REQ-039 fil_len=0, ifm_len=0 -> no mem_ren, no writes; done exactly 2 cycles after start.
REQ-040 fil_len=2, ready_fil low 4 cycles at first WR -> w_en_fil delayed 4 cycles, data_in_fil stable throughout, single strobe per word.
REQ-041 base_addr=0xFE, fil_len=3 -> reads 0xFE, 0xFF, 0x00.
REQ-042 rst_n low during third IFM word of a 5-word run, start pulsed while busy earlier -> all outputs 0 next cycle, no done; fresh start after release runs full sequence.
